// File: rtl/pattern_framer_if.sv
// rtl/pattern_framer_if.sv - payload enqueue, frame request and DBUS output bundle for pattern_framer
interface pattern_framer_if;
   logic [15:0] din;
   logic        din_valid;
   logic        din_ready;
   logic        send;
   logic [4:0]  len;
   logic [15:0] dbus;
   logic        dbus_valid;
   logic        busy;
   logic        done;
   logic        err;

   modport master (
      output din, din_valid, send, len,
      input  din_ready, dbus, dbus_valid, busy, done, err
   );

   modport slave (
      input  din, din_valid, send, len,
      output din_ready, dbus, dbus_valid, busy, done, err
   );
endinterface

// File: rtl/pattern_framer.sv
// rtl/pattern_framer.sv - DBUS sync-pattern frame transmitter with payload FIFO; checksum word enabled by PATTERN_FRAMER_CSUM_EN
module pattern_framer #(
   parameter logic [15:0] SYNC0      = 16'hAAAA,
   parameter logic [15:0] SYNC1      = 16'h5555,
   parameter logic [15:0] IDLE_WORD  = 16'h0000,
   parameter int          FIFO_DEPTH = 16
) (
   input logic             clk,
   input logic             rst,
   pattern_framer_if.slave bus
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [2:0] {IDLE, SYNC0_S, SYNC1_S, LEN_S, PAY_S, CSUM_S} state_t;

`ifdef PATTERN_FRAMER_CSUM_EN
   localparam state_t TAIL = CSUM_S;
`else
   localparam state_t TAIL = IDLE;
`endif

   state_t        state, state_n;
   logic [15:0]   mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          wr_en, pop, accept, reject, len_ok;
   logic [4:0]    len_q, pay_cnt;
   logic [15:0]   dbus_n, rd_word;
   logic          valid_n;
`ifdef PATTERN_FRAMER_CSUM_EN
   logic [15:0]   csum;
`endif

   // The DBUS word for a state is registered one edge later, so the state leads the bus by a cycle.
   assign bus.din_ready = (count != CW'(FIFO_DEPTH));
   assign wr_en         = bus.din_valid & bus.din_ready;
   assign rd_word       = mem[rd_ptr];
   assign len_ok        = (int'(bus.len) <= FIFO_DEPTH) && (int'(bus.len) <= int'(count));

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_n;
   end

   // Next state, next DBUS word, FIFO pop and SEND accept/reject decisions
   always_comb begin
      state_n = state;
      dbus_n  = IDLE_WORD;
      valid_n = 1'b0;
      pop     = 1'b0;
      accept  = 1'b0;
      reject  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.send) begin
               if (len_ok) begin
                  accept  = 1'b1;
                  state_n = SYNC0_S;
               end else begin
                  reject = 1'b1;
               end
            end
         end
         SYNC0_S: begin
            dbus_n  = SYNC0;
            valid_n = 1'b1;
            state_n = SYNC1_S;
         end
         SYNC1_S: begin
            dbus_n  = SYNC1;
            valid_n = 1'b1;
            state_n = LEN_S;
         end
         LEN_S: begin
            dbus_n  = {11'b0, len_q};
            valid_n = 1'b1;
            state_n = (len_q == 5'd0) ? TAIL : PAY_S;
         end
         PAY_S: begin
            dbus_n  = rd_word;
            valid_n = 1'b1;
            pop     = 1'b1;
            state_n = (pay_cnt == len_q - 5'd1) ? TAIL : PAY_S;
         end
`ifdef PATTERN_FRAMER_CSUM_EN
         CSUM_S: begin
            dbus_n  = csum;
            valid_n = 1'b1;
            state_n = IDLE;
         end
`endif
         default: state_n = IDLE;
      endcase
   end

   // FIFO storage; contents need no reset because the pointers and count define emptiness
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= bus.din;
   end

   // FIFO pointers and occupancy count
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PW'(1);
         if (pop)   rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(wr_en) - CW'(pop);
      end
   end

   // Latched frame length and payload word counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         len_q   <= '0;
         pay_cnt <= '0;
      end else if (accept) begin
         len_q   <= bus.len;
         pay_cnt <= '0;
      end else if (pop) begin
         pay_cnt <= pay_cnt + 5'd1;
      end
   end

`ifdef PATTERN_FRAMER_CSUM_EN
   // Running XOR of the length word and every popped payload word
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        csum <= '0;
      else if (accept) csum <= {11'b0, bus.len};
      else if (pop)    csum <= csum ^ rd_word;
   end
`endif

   // Registered bus outputs; DONE fires on the first cycle after the valid window closes
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.dbus       <= IDLE_WORD;
         bus.dbus_valid <= 1'b0;
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
         bus.err        <= 1'b0;
      end else begin
         bus.dbus       <= dbus_n;
         bus.dbus_valid <= valid_n;
         bus.busy       <= valid_n;
         bus.done       <= bus.dbus_valid & ~valid_n;
         bus.err        <= reject;
      end
   end
endmodule

// File: tb/tb_pattern_framer.sv
// tb/tb_pattern_framer.sv - table-driven and directed checks for pattern_framer
module tb_pattern_framer;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_total = 0;
   int   n_pass  = 0;

   pattern_framer_if bus();

   pattern_framer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        dv;
      logic [15:0] din;
      logic        send;
      logic [4:0]  len;
      logic [15:0] e_dbus;
      logic        e_valid;
      logic        e_done;
      logic        e_err;
      logic        e_ready;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic dv, input logic [15:0] din, input logic send, input logic [4:0] len,
                      input logic [15:0] e_dbus, input logic e_valid, input logic e_done,
                      input logic e_err, input logic e_ready);
      vec_t v;
      v.dv = dv; v.din = din; v.send = send; v.len = len;
      v.e_dbus = e_dbus; v.e_valid = e_valid; v.e_done = e_done; v.e_err = e_err; v.e_ready = e_ready;
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s actual=%h expected=%h", name, act, exp);
      else             n_pass++;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_word(input string name, input logic [15:0] w, input logic v);
      chk(name, {bus.dbus, bus.dbus_valid, bus.busy}, {w, v, v});
   endtask

   initial begin
      logic [15:0] x;

      bus.din = '0; bus.din_valid = 1'b0; bus.send = 1'b0; bus.len = '0;
      @(negedge clk);
      chk("reset_state", {bus.dbus, bus.dbus_valid, bus.busy, bus.done, bus.err, bus.din_ready},
          {16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // basic 3-word frame
      add(1, 16'h0040, 0, 0, 16'h0000, 0, 0, 0, 1);
      add(1, 16'h0133, 0, 0, 16'h0000, 0, 0, 0, 1);
      add(1, 16'h5576, 0, 0, 16'h0000, 0, 0, 0, 1);
      add(0, 16'h0000, 1, 3, 16'h0000, 0, 0, 0, 1);
      add(0, 16'h0000, 0, 0, 16'hAAAA, 1, 0, 0, 1);
      add(0, 16'h0000, 0, 0, 16'h5555, 1, 0, 0, 1);
      add(0, 16'h0000, 0, 0, 16'h0003, 1, 0, 0, 1);
      add(0, 16'h0000, 0, 0, 16'h0040, 1, 0, 0, 1);
      add(0, 16'h0000, 0, 0, 16'h0133, 1, 0, 0, 1);
      add(0, 16'h0000, 0, 0, 16'h5576, 1, 0, 0, 1);
`ifdef PATTERN_FRAMER_CSUM_EN
      add(0, 16'h0000, 0, 0, 16'h0003 ^ 16'h0040 ^ 16'h0133 ^ 16'h5576, 1, 0, 0, 1);
`endif
      add(0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 1);
      add(0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 1);

      // rejected SENDs leave FIFO with one word
      add(1, 16'h1111, 0, 0, 16'h0000, 0, 0, 0, 1);
      add(0, 16'h0000, 1, 2, 16'h0000, 0, 0, 1, 1);
      add(0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 1);
      add(0, 16'h0000, 1, 17, 16'h0000, 0, 0, 1, 1);
      add(0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 1);

      // LEN=0 frame, FIFO untouched
      add(0, 16'h0000, 1, 0, 16'h0000, 0, 0, 0, 1);
      add(0, 16'h0000, 0, 0, 16'hAAAA, 1, 0, 0, 1);
      add(0, 16'h0000, 0, 0, 16'h5555, 1, 0, 0, 1);
      add(0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 1);
`ifdef PATTERN_FRAMER_CSUM_EN
      add(0, 16'h0000, 0, 0, 16'h0000, 1, 0, 0, 1);
`endif
      add(0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 1);

      // the retained word is still there
      add(0, 16'h0000, 1, 1, 16'h0000, 0, 0, 0, 1);
      add(0, 16'h0000, 0, 0, 16'hAAAA, 1, 0, 0, 1);
      add(0, 16'h0000, 0, 0, 16'h5555, 1, 0, 0, 1);
      add(0, 16'h0000, 0, 0, 16'h0001, 1, 0, 0, 1);
      add(0, 16'h0000, 0, 0, 16'h1111, 1, 0, 0, 1);
`ifdef PATTERN_FRAMER_CSUM_EN
      add(0, 16'h0000, 0, 0, 16'h0001 ^ 16'h1111, 1, 0, 0, 1);
`endif
      add(0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 1);

      // back-to-back frames with SEND held through BUSY
      add(1, 16'hA1A1, 0, 0, 16'h0000, 0, 0, 0, 1);
      add(1, 16'hA2A2, 0, 0, 16'h0000, 0, 0, 0, 1);
      add(1, 16'hA3A3, 0, 0, 16'h0000, 0, 0, 0, 1);
      add(1, 16'hA4A4, 0, 0, 16'h0000, 0, 0, 0, 1);
      add(0, 16'h0000, 1, 2, 16'h0000, 0, 0, 0, 1);
      add(0, 16'h0000, 1, 2, 16'hAAAA, 1, 0, 0, 1);
      add(0, 16'h0000, 1, 2, 16'h5555, 1, 0, 0, 1);
      add(0, 16'h0000, 1, 2, 16'h0002, 1, 0, 0, 1);
      add(0, 16'h0000, 1, 2, 16'hA1A1, 1, 0, 0, 1);
      add(0, 16'h0000, 1, 2, 16'hA2A2, 1, 0, 0, 1);
`ifdef PATTERN_FRAMER_CSUM_EN
      add(0, 16'h0000, 1, 2, 16'h0002 ^ 16'hA1A1 ^ 16'hA2A2, 1, 0, 0, 1);
`endif
      add(0, 16'h0000, 1, 2, 16'h0000, 0, 1, 0, 1);
      add(0, 16'h0000, 1, 2, 16'hAAAA, 1, 0, 0, 1);
      add(0, 16'h0000, 1, 2, 16'h5555, 1, 0, 0, 1);
      add(0, 16'h0000, 1, 2, 16'h0002, 1, 0, 0, 1);
      add(0, 16'h0000, 1, 2, 16'hA3A3, 1, 0, 0, 1);
      add(0, 16'h0000, 1, 2, 16'hA4A4, 1, 0, 0, 1);
`ifdef PATTERN_FRAMER_CSUM_EN
      add(0, 16'h0000, 1, 2, 16'h0002 ^ 16'hA3A3 ^ 16'hA4A4, 1, 0, 0, 1);
`endif
      add(0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 1);
      add(0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 1);

      foreach (vq[i]) begin
         bus.din_valid = vq[i].dv;
         bus.din       = vq[i].din;
         bus.send      = vq[i].send;
         bus.len       = vq[i].len;
         step();
         chk($sformatf("row%0d", i),
             {bus.dbus, bus.dbus_valid, bus.busy, bus.done, bus.err, bus.din_ready},
             {vq[i].e_dbus, vq[i].e_valid, vq[i].e_valid, vq[i].e_done, vq[i].e_err, vq[i].e_ready});
      end
      bus.din_valid = 1'b0; bus.send = 1'b0; bus.len = '0;

      // fill to full, 17th write dropped, then a 16-word frame
      for (int i = 0; i < 17; i++) begin
         bus.din_valid = 1'b1;
         bus.din       = (i == 16) ? 16'hEEBB : 16'h1000 + 16'(i);
         step();
         chk($sformatf("fill_ready%0d", i), {31'b0, bus.din_ready}, (i < 15) ? 32'd1 : 32'd0);
      end
      bus.din_valid = 1'b0;
      bus.send = 1'b1; bus.len = 5'd16;
      step();
      bus.send = 1'b0; bus.len = '0;
      step(); check_word("full_sync0", 16'hAAAA, 1'b1);
      step(); check_word("full_sync1", 16'h5555, 1'b1);
      step(); check_word("full_len", 16'h0010, 1'b1);
      chk("full_ready_before_pop", {31'b0, bus.din_ready}, 32'd0);
      x = 16'h0010;
      for (int i = 0; i < 16; i++) begin
         step();
         check_word($sformatf("full_pay%0d", i), 16'h1000 + 16'(i), 1'b1);
         x = x ^ (16'h1000 + 16'(i));
         if (i == 0) chk("full_ready_after_pop", {31'b0, bus.din_ready}, 32'd1);
      end
`ifdef PATTERN_FRAMER_CSUM_EN
      step(); check_word("full_csum", x, 1'b1);
`endif
      step();
      chk("full_done", {30'b0, bus.done, bus.dbus_valid}, 32'd2);

      // reset mid-payload
      for (int i = 0; i < 3; i++) begin
         bus.din_valid = 1'b1; bus.din = 16'h2001 + 16'(i);
         step();
      end
      bus.din_valid = 1'b0;
      bus.send = 1'b1; bus.len = 5'd3;
      step();
      bus.send = 1'b0; bus.len = '0;
      step(); step(); step(); step();
      check_word("rst_pay0", 16'h2001, 1'b1);
      #2 rst = 1'b0;
      #1 chk("rst_async", {bus.dbus, bus.dbus_valid, bus.busy, bus.din_ready}, {16'h0000, 1'b0, 1'b0, 1'b1});
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("rst_nodone%0d", i), {29'b0, bus.done, bus.dbus_valid, bus.busy}, 32'd0);
      end
      bus.send = 1'b1; bus.len = 5'd1;
      step();
      bus.send = 1'b0; bus.len = '0;
      chk("rst_fifo_empty_err", {30'b0, bus.err, bus.din_ready}, 32'd3);
      step();
      chk("rst_err_clear", {31'b0, bus.err}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
